// File: rtl/axi4_mem_slave.sv
// AXI4 slave backed by a word-addressed memory; INCR/FIXED bursts of 32-bit beats.
// First read beat one cycle after AR accept; write/read paths stall only on W/R/B handshakes.
module axi4_mem_slave #(
    parameter int MEM_DEPTH = 256,
    parameter int ID_WIDTH  = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [31:0]         S_AXI_AWADDR,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [ID_WIDTH-1:0] S_AXI_AWID,
    input  logic [7:0]          S_AXI_AWLEN,
    input  logic [2:0]          S_AXI_AWSIZE,
    input  logic [1:0]          S_AXI_AWBURST,
    input  logic [2:0]          S_AXI_AWPROT,
    input  logic [3:0]          S_AXI_AWCACHE,
    input  logic                S_AXI_AWLOCK,
    input  logic [3:0]          S_AXI_AWQOS,
    input  logic [3:0]          S_AXI_AWREGION,
    input  logic [31:0]         S_AXI_WDATA,
    input  logic [3:0]          S_AXI_WSTRB,
    input  logic                S_AXI_WVALID,
    input  logic                S_AXI_WLAST,
    output logic                S_AXI_WREADY,
    output logic [1:0]          S_AXI_BRESP,
    output logic [ID_WIDTH-1:0] S_AXI_BID,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    input  logic [31:0]         S_AXI_ARADDR,
    input  logic                S_AXI_ARVALID,
    input  logic [ID_WIDTH-1:0] S_AXI_ARID,
    input  logic [7:0]          S_AXI_ARLEN,
    input  logic [2:0]          S_AXI_ARSIZE,
    input  logic [1:0]          S_AXI_ARBURST,
    input  logic [2:0]          S_AXI_ARPROT,
    input  logic [3:0]          S_AXI_ARCACHE,
    input  logic                S_AXI_ARLOCK,
    input  logic [3:0]          S_AXI_ARQOS,
    input  logic [3:0]          S_AXI_ARREGION,
    output logic                S_AXI_ARREADY,
    output logic [31:0]         S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic [ID_WIDTH-1:0] S_AXI_RID,
    output logic                S_AXI_RLAST,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY
);

    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [31:0] mem [MEM_DEPTH];

    logic unused_sideband;
    assign unused_sideband = ^{S_AXI_AWPROT, S_AXI_AWCACHE, S_AXI_AWLOCK, S_AXI_AWQOS,
                               S_AXI_AWREGION, S_AXI_ARPROT, S_AXI_ARCACHE, S_AXI_ARLOCK,
                               S_AXI_ARQOS, S_AXI_ARREGION};

    // ---------------- write path ----------------
    wstate_t             wstate_q;
    logic                awready_q, wready_q, bvalid_q;
    logic [1:0]          bresp_q;
    logic [ID_WIDTH-1:0] bid_q, wid_q;
    logic [31:0]         waddr_q;
    logic [7:0]          wlen_q, wcnt_q;
    logic                wfixed_q, wbad_q, werr_q;

    logic w_fire, w_oor, w_last, w_beat_err, mem_we;
    assign w_fire     = (wstate_q == W_DATA) && S_AXI_WVALID && wready_q;
    assign w_oor      = |waddr_q[31:AW+2];
    assign w_last     = (wcnt_q == wlen_q);
    assign w_beat_err = wbad_q | w_oor | (S_AXI_WLAST != w_last);
    assign mem_we     = w_fire && !wbad_q && !w_oor;

    // Memory has no reset so a reset mid-burst keeps bytes already written.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (S_AXI_WSTRB[b]) mem[waddr_q[AW+1:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= '0;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wfixed_q  <= 1'b0;
            wbad_q    <= 1'b0;
            werr_q    <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (S_AXI_AWVALID && awready_q) begin
                        waddr_q   <= S_AXI_AWADDR;
                        wid_q     <= S_AXI_AWID;
                        wlen_q    <= S_AXI_AWLEN;
                        wfixed_q  <= (S_AXI_AWBURST == 2'b00);
                        wbad_q    <= (S_AXI_AWSIZE != 3'b010) || S_AXI_AWBURST[1];
                        wcnt_q    <= '0;
                        werr_q    <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (!wfixed_q) waddr_q <= waddr_q + 32'd4;
                        // LEN alone ends the burst; a stray WLAST only poisons BRESP.
                        if (w_last) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= wid_q;
                            bresp_q  <= (werr_q | w_beat_err) ? 2'b10 : 2'b00;
                            wstate_q <= W_RESP;
                        end else begin
                            wcnt_q <= wcnt_q + 8'd1;
                            werr_q <= werr_q | w_beat_err;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= 2'b00;
                        bid_q     <= '0;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    rstate_t             rstate_q;
    logic                arready_q, rvalid_q, rlast_q;
    logic [31:0]         rdata_q, raddr_q;
    logic [1:0]          rresp_q;
    logic [ID_WIDTH-1:0] rid_q;
    logic [7:0]          rlen_q, rcnt_q;
    logic                rfixed_q, rbad_q;

    // Address/data of the beat to be presented after the current handshake.
    logic [31:0] r_nxt_addr, r_nxt_data;
    logic        r_nxt_bad, r_nxt_err, r_fire, r_last;
    assign r_nxt_addr = (rstate_q == R_IDLE) ? S_AXI_ARADDR :
                        (rfixed_q ? raddr_q : raddr_q + 32'd4);
    assign r_nxt_bad  = (rstate_q == R_IDLE) ?
                        ((S_AXI_ARSIZE != 3'b010) || S_AXI_ARBURST[1]) : rbad_q;
    assign r_nxt_err  = r_nxt_bad | (|r_nxt_addr[31:AW+2]);
    assign r_nxt_data = r_nxt_err ? 32'd0 : mem[r_nxt_addr[AW+1:2]];
    assign r_fire     = rvalid_q && S_AXI_RREADY;
    assign r_last     = (rcnt_q == rlen_q);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rfixed_q  <= 1'b0;
            rbad_q    <= 1'b0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (S_AXI_ARVALID && arready_q) begin
                        raddr_q   <= S_AXI_ARADDR;
                        rid_q     <= S_AXI_ARID;
                        rlen_q    <= S_AXI_ARLEN;
                        rcnt_q    <= '0;
                        rfixed_q  <= (S_AXI_ARBURST == 2'b00);
                        rbad_q    <= r_nxt_bad;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= r_nxt_data;
                        rresp_q   <= r_nxt_err ? 2'b10 : 2'b00;
                        rlast_q   <= (S_AXI_ARLEN == 8'd0);
                        rstate_q  <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (r_last) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rdata_q   <= '0;
                            rresp_q   <= 2'b00;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            rcnt_q  <= rcnt_q + 8'd1;
                            raddr_q <= r_nxt_addr;
                            rdata_q <= r_nxt_data;
                            rresp_q <= r_nxt_err ? 2'b10 : 2'b00;
                            rlast_q <= (rcnt_q + 8'd1 == rlen_q);
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BID     = bid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RID     = rid_q;
    assign S_AXI_RLAST   = rlast_q;

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Bench for axi4_mem_slave: write/read-back vector table plus a mid-burst reset sequence.
module tb_axi4_mem_slave;
    localparam int DEPTH = 256;
    localparam int IDW   = 4;
    localparam int AWB   = $clog2(DEPTH);

    logic ACLK = 1'b0;
    logic ARESETn = 1'b1;
    always #5 ACLK = ~ACLK;

    logic [31:0]    awaddr = '0, wdata = '0, araddr = '0;
    logic           awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
    logic [IDW-1:0] awid = '0, arid = '0;
    logic [7:0]     awlen = '0, arlen = '0;
    logic [2:0]     awsize = 3'd2, arsize = 3'd2;
    logic [1:0]     awburst = 2'b01, arburst = 2'b01;
    logic [3:0]     wstrb = 4'hF;
    logic [2:0]     prot0 = '0;
    logic [3:0]     nib0 = '0;
    logic           bit0 = 1'b0;

    logic           awready, wready, bvalid, arready, rvalid, rlast;
    logic [1:0]     bresp, rresp;
    logic [IDW-1:0] bid, rid;
    logic [31:0]    rdata;

    axi4_mem_slave #(.MEM_DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_AWID(awid), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
        .S_AXI_AWPROT(prot0), .S_AXI_AWCACHE(nib0), .S_AXI_AWLOCK(bit0), .S_AXI_AWQOS(nib0),
        .S_AXI_AWREGION(nib0),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WLAST(wlast),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BID(bid), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARID(arid), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_ARPROT(prot0), .S_AXI_ARCACHE(nib0), .S_AXI_ARLOCK(bit0), .S_AXI_ARQOS(nib0),
        .S_AXI_ARREGION(nib0), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RID(rid), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [DEPTH];

    typedef struct {
        logic [31:0]    data;
        logic [1:0]     resp;
        logic           last;
        logic [IDW-1:0] id;
    } rbeat_t;

    typedef struct {
        logic [31:0]    bresp_id;
    } bexp_t;

    rbeat_t rq[$];
    bexp_t  bq[$];

    typedef struct {
        logic [31:0] waddr;
        logic [7:0]  wlen;
        logic [1:0]  wburst;
        logic [2:0]  wsize;
        logic [3:0]  strb;
        logic [31:0] base;
        logic        bad_last;
        logic [1:0]  exp_bresp;
        logic [31:0] raddr;
        logic [7:0]  rlen;
        logic [2:0]  rsize;
        logic        rtog;
        logic [31:0] exp_first;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] strb, input logic [31:0] base,
                            input logic bad_last, input logic [IDW-1:0] id, input logic [1:0] exp_bresp);
        int          beat = 0;
        int          g = 0;
        logic        awf, wf, bad;
        logic [31:0] a = addr;
        bexp_t       e;
        bad = (size != 3'd2) || burst[1];
        @(negedge ACLK);
        awaddr = addr; awlen = len; awburst = burst; awsize = size; awid = id; awvalid = 1'b1;
        wstrb = strb; wdata = base; wlast = bad_last ? 1'b1 : (len == 8'd0); wvalid = 1'b1;
        while ((awvalid || wvalid) && g < 300) begin
            awf = awvalid && awready;
            wf  = wvalid && wready;
            if (wf) begin
                if (!bad && a < 32'(4 * DEPTH))
                    for (int b = 0; b < 4; b++)
                        if (strb[b]) model[a[AWB+1:2]][8*b +: 8] = wdata[8*b +: 8];
                if (burst != 2'b00) a = a + 32'd4;
            end
            @(posedge ACLK);
            @(negedge ACLK);
            g++;
            if (awf) awvalid = 1'b0;
            if (wf) begin
                beat++;
                if (beat > int'(len)) wvalid = 1'b0;
                else begin
                    wdata = base + 32'(beat);
                    wlast = bad_last ? (beat == 0) : (beat == int'(len));
                end
            end
        end
        if (g >= 300) check("write_handshake_timeout", 32'd1, 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        e.bresp_id = {26'd0, exp_bresp, id};
        bq.push_back(e);
        bready = 1'b1;
        g = 0;
        while (!bvalid && g < 50) begin
            @(negedge ACLK);
            g++;
        end
        if (!bvalid) begin
            check("bvalid_timeout", 32'd0, 32'd1);
            void'(bq.pop_front());
        end else begin
            e = bq.pop_front();
            check("bresp", {30'd0, bresp}, {30'd0, e.bresp_id[IDW+1:IDW]});
            check("bid", {28'd0, bid}, {28'd0, e.bresp_id[IDW-1:0]});
        end
        @(negedge ACLK);
        bready = 1'b0;
        check("bvalid_clear", {31'd0, bvalid}, 32'd0);
        check("awready_back", {31'd0, awready}, 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic tog, input logic [IDW-1:0] id, input logic [31:0] exp_first);
        int          g = 0;
        int          got = 0;
        int          c = 0;
        logic        arf, stalled = 1'b0, bad, oor;
        logic [31:0] a = addr;
        logic [31:0] s_data;
        logic [1:0]  s_resp;
        logic        s_last;
        rbeat_t      e;
        bad = (size != 3'd2);
        for (int i = 0; i <= int'(len); i++) begin
            oor    = (a >= 32'(4 * DEPTH));
            e.data = (bad || oor) ? 32'd0 : model[a[AWB+1:2]];
            e.resp = (bad || oor) ? 2'b10 : 2'b00;
            e.last = (i == int'(len));
            e.id   = id;
            rq.push_back(e);
            a = a + 32'd4;
        end
        @(negedge ACLK);
        araddr = addr; arlen = len; arsize = size; arburst = 2'b01; arid = id; arvalid = 1'b1;
        while (arvalid && g < 50) begin
            arf = arvalid && arready;
            @(posedge ACLK);
            @(negedge ACLK);
            g++;
            if (arf) arvalid = 1'b0;
        end
        if (arvalid) check("ar_timeout", 32'd1, 32'd0);
        arvalid = 1'b0;
        g = 0;
        while (got <= int'(len) && g < 300) begin
            rready = tog ? (c % 2 == 0) : 1'b1;
            c++;
            if (rvalid) begin
                if (stalled) begin
                    check("stall_rdata", rdata, s_data);
                    check("stall_rresp", {30'd0, rresp}, {30'd0, s_resp});
                    check("stall_rlast", {31'd0, rlast}, {31'd0, s_last});
                end
                if (rready) begin
                    e = rq.pop_front();
                    check("rdata", rdata, e.data);
                    check("rresp", {30'd0, rresp}, {30'd0, e.resp});
                    check("rlast", {31'd0, rlast}, {31'd0, e.last});
                    check("rid", {28'd0, rid}, {28'd0, e.id});
                    if (got == 0) check("rdata_first", rdata, exp_first);
                    got++;
                    stalled = 1'b0;
                end else begin
                    s_data = rdata; s_resp = rresp; s_last = rlast;
                    stalled = 1'b1;
                end
            end
            @(negedge ACLK);
            g++;
        end
        rready = 1'b0;
        if (got <= int'(len)) check("read_beats_timeout", 32'(got), 32'(int'(len) + 1));
        rq.delete();
        check("rvalid_clear", {31'd0, rvalid}, 32'd0);
        check("arready_back", {31'd0, arready}, 32'd1);
    endtask

    initial begin
        //          waddr        len   burst  size  strb   base           blast bresp  raddr        rlen  rsize tog exp_first
        vt[0] = '{32'h4,       8'd0, 2'b01, 3'd2, 4'hF, 32'h12345678, 1'b0, 2'b00, 32'h4,       8'd0, 3'd2, 1'b0, 32'h12345678};
        vt[1] = '{32'h10,      8'd3, 2'b01, 3'd2, 4'hF, 32'hA0,       1'b0, 2'b00, 32'h10,      8'd3, 3'd2, 1'b1, 32'hA0};
        vt[2] = '{32'h20,      8'd2, 2'b00, 3'd2, 4'hF, 32'h1,        1'b0, 2'b00, 32'h20,      8'd0, 3'd2, 1'b0, 32'h3};
        vt[3] = '{32'h30,      8'd0, 2'b01, 3'd2, 4'hF, 32'hFFFFFFFF, 1'b0, 2'b00, 32'h30,      8'd0, 3'd2, 1'b0, 32'hFFFFFFFF};
        vt[4] = '{32'h30,      8'd0, 2'b01, 3'd2, 4'h5, 32'h0,        1'b0, 2'b00, 32'h30,      8'd0, 3'd2, 1'b0, 32'hFF00FF00};
        vt[5] = '{32'h3FC,     8'd1, 2'b01, 3'd2, 4'hF, 32'hC0,       1'b0, 2'b10, 32'h3FC,     8'd1, 3'd2, 1'b0, 32'hC0};
        vt[6] = '{32'h40,      8'd0, 2'b01, 3'd2, 4'hF, 32'h5555AAAA, 1'b0, 2'b00, 32'h40,      8'd0, 3'd2, 1'b0, 32'h5555AAAA};
        vt[7] = '{32'h40,      8'd1, 2'b10, 3'd2, 4'hF, 32'hDEAD0000, 1'b0, 2'b10, 32'h40,      8'd0, 3'd2, 1'b0, 32'h5555AAAA};
        vt[8] = '{32'h48,      8'd0, 2'b01, 3'd2, 4'hF, 32'h11,       1'b0, 2'b00, 32'h48,      8'd0, 3'd1, 1'b0, 32'h0};
        vt[9] = '{32'h60,      8'd1, 2'b01, 3'd2, 4'hF, 32'h70,       1'b1, 2'b10, 32'h60,      8'd1, 3'd2, 1'b0, 32'h70};

        #1 ARESETn = 1'b0;
        repeat (2) @(negedge ACLK);
        check("reset_ctrl_outs", {24'd0, awready, wready, bvalid, arready, rvalid, rlast, bresp}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        ARESETn = 1'b1;
        #1 check("awready_before_edge", {31'd0, awready}, 32'd0);
        @(posedge ACLK);
        #1 check("awready_after_release", {31'd0, awready}, 32'd1);
        check("arready_after_release", {31'd0, arready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            do_write(vt[i].waddr, vt[i].wlen, vt[i].wburst, vt[i].wsize, vt[i].strb, vt[i].base,
                     vt[i].bad_last, 4'(i), vt[i].exp_bresp);
            do_read(vt[i].raddr, vt[i].rlen, vt[i].rsize, vt[i].rtog, 4'(i + 3), vt[i].exp_first);
        end

        // Reset while beat 1 of a 4-beat write is on the bus.
        @(negedge ACLK);
        awaddr = 32'h50; awlen = 8'd3; awburst = 2'b01; awsize = 3'd2; awid = 4'd5; awvalid = 1'b1;
        wdata = 32'hB0; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        awvalid = 1'b0;
        check("wready_after_aw", {31'd0, wready}, 32'd1);
        model[32'h50 >> 2] = 32'hB0;
        @(posedge ACLK);
        @(negedge ACLK);
        wdata = 32'hB1;
        #1 ARESETn = 1'b0;
        #1 check("midburst_reset_outs",
                 {14'd0, awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rid, rlast}, 32'd0);
        check("midburst_reset_rdata", rdata, 32'd0);
        wvalid = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1 check("awready_held_low", {31'd0, awready}, 32'd0);
        @(posedge ACLK);
        #1 check("awready_rise", {31'd0, awready}, 32'd1);
        do_read(32'h50, 8'd0, 3'd2, 1'b0, 4'd9, 32'hB0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
